// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Walks every N-bit input combination of an external gate and
//            captures its truth table; optional expected-table comparison
//            is built when TRUTH_TABLE_SWEEPER_COMPARE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [(1<<N)-1:0]   expected,
    output logic [N-1:0]        gate_in,
    input  logic                gate_out,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   table_out,
    output logic                pass,
    output logic                err,
    output logic [N-1:0]        fail_idx
);

    localparam int           c_TW       = 1 << N;
    localparam logic [N:0]   c_LAST_IDX = (N+1)'(c_TW - 1);
    localparam logic [3:0]   c_RELOAD   = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N:0]        r_idx;
    logic [N:0]        w_idx_inc;
    logic [3:0]        r_cnt;
    logic [N-1:0]      r_gate_in;
    logic [c_TW-1:0]   r_table;
    logic              w_last;
    logic              w_accept;

    assign w_last    = (r_idx == c_LAST_IDX);
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_idx_inc = r_idx + (N+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_DRIVE;
            S_DRIVE:  if (r_cnt == 4'd0) w_next = S_SAMPLE;
            S_SAMPLE: w_next = w_last ? S_DONE : S_DRIVE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_cnt     <= '0;
            r_gate_in <= '0;
            r_table   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx     <= '0;
                        r_cnt     <= c_RELOAD;
                        r_gate_in <= '0;
                        r_table   <= '0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_table[r_idx[N-1:0]] <= gate_out;
                    // Gate inputs park at 0 for the DONE cycle.
                    if (w_last) begin
                        r_gate_in <= '0;
                    end else begin
                        r_idx     <= w_idx_inc;
                        r_gate_in <= w_idx_inc[N-1:0];
                        r_cnt     <= c_RELOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign gate_in   = r_gate_in;
    assign table_out = r_table;
    assign busy      = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    assign done      = (r_state == S_DONE);

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    logic [c_TW-1:0]   r_expected;
    logic              r_err;
    logic              r_pass;
    logic [N-1:0]      r_fail_idx;
    logic              w_mismatch;

    assign w_mismatch = (r_state == S_SAMPLE) && (gate_out != r_expected[r_idx[N-1:0]]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expected <= '0;
            r_err      <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
        end else if (w_accept) begin
            r_expected <= expected;
            r_err      <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
        end else if (r_state == S_SAMPLE) begin
            if (w_mismatch && !r_err) begin
                r_err      <= 1'b1;
                r_fail_idx <= r_idx[N-1:0];
            end
            // Include the final sample's own mismatch so pass is right in DONE.
            if (w_last) begin
                r_pass <= !(r_err || w_mismatch);
            end
        end
    end

    assign err      = r_err;
    assign pass     = r_pass;
    assign fail_idx = r_fail_idx;
`else
    logic w_unused_expected;
    logic w_unused_accept;

    assign w_unused_expected = ^expected;
    assign w_unused_accept   = w_accept;
    assign err               = 1'b0;
    assign pass              = 1'b0;
    assign fail_idx          = '0;
`endif

endmodule

`default_nettype wire
